// File: rtl/obi_mem_pkg.sv
// obi_mem_pkg: bus widths and the response record shared by the OBI memory responder files.
package obi_mem_pkg;

    localparam int unsigned BUS_AW  = 32;
    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned BUS_BEW = 4;

    // One response as it travels from the handshake to the rvalid cycle.
    typedef struct packed {
        logic [BUS_DW-1:0] rdata;
        logic              err;
    } resp_t;

    // An empty slot carries all-zero data so idle outputs stay quiet.
    localparam resp_t RESP_IDLE = '{rdata: '0, err: 1'b0};

endpackage

// File: rtl/resp_delay_line.sv
// resp_delay_line: fixed-depth shift pipeline that delays each response by DEPTH cycles.
module resp_delay_line
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  clk_i,
    input  logic  clr_i,
    input  logic  valid_i,
    input  resp_t resp_i,
    output logic  valid_o,
    output resp_t resp_o
);

    logic  valid_q [DEPTH];
    resp_t resp_q  [DEPTH];

    // Advance every slot by one each cycle; a clear empties the whole line so no stale response survives.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_q[i] <= 1'b0;
                resp_q[i]  <= RESP_IDLE;
            end
        end else begin
            valid_q[0] <= valid_i;
            resp_q[0]  <= valid_i ? resp_i : RESP_IDLE;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign resp_o  = resp_q[DEPTH-1];

endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI data-port memory with programmable grant stall and fixed response latency.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned GNT_STALL = 0,
    parameter int unsigned RESP_LAT  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               data_req_i,
    output logic               data_gnt_o,
    input  logic               data_we_i,
    input  logic [BUS_BEW-1:0] data_be_i,
    input  logic [BUS_AW-1:0]  data_addr_i,
    input  logic [BUS_DW-1:0]  data_wdata_i,
    output logic               data_rvalid_o,
    output logic [BUS_DW-1:0]  data_rdata_o,
    output logic               data_err_o
);

    localparam int unsigned        IDX_W        = $clog2(MEM_WORDS);
    localparam logic [3:0]         STALL_RELOAD = GNT_STALL[3:0];
    localparam logic [BUS_AW-3:0]  BASE_WORD    = BASE_ADDR[BUS_AW-1:2];
    localparam logic [BUS_AW-3:0]  WORDS_L      = MEM_WORDS[BUS_AW-3:0];

    logic [3:0]        stallCnt_q;
    logic [3:0]        stallCnt_d;
    logic              handshake;
    logic [BUS_AW-3:0] wordOff;
    logic              inRange;
    logic [IDX_W-1:0]  wordIdx;
    logic              wrEn;
    resp_t             accResp;
    logic              dlValid;
    resp_t             dlResp;
    logic              unused_addrLsb;

    logic [BUS_DW-1:0] mem_q [MEM_WORDS];

    // Byte offset within the word never matters: accesses are always whole-word aligned.
    assign unused_addrLsb = ^data_addr_i[1:0];

    // Grant only once the stall counter has run out, and never while reset holds the block.
    assign data_gnt_o = data_req_i & (stallCnt_q == 4'd0) & ~rst_i;
    assign handshake  = data_gnt_o;

    // Word offset from the window base; an address below the base wraps to a huge offset and fails the compare.
    assign wordOff = data_addr_i[BUS_AW-1:2] - BASE_WORD;
    assign inRange = (wordOff < WORDS_L);
    assign wordIdx = wordOff[IDX_W-1:0];
    assign wrEn    = handshake & data_we_i & inRange;

    // Next stall count: reload after a handshake, count down only while a request is waiting.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (handshake) begin
            stallCnt_d = STALL_RELOAD;
        end else if (data_req_i && (stallCnt_q != 4'd0)) begin
            stallCnt_d = stallCnt_q - 4'd1;
        end
    end

    // Stall counter register; reset leaves it armed with the full stall so the first grant is also delayed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt_q <= STALL_RELOAD;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    // Storage: per-lane write at the handshake edge, no reset so it maps onto a plain RAM.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            for (int lane = 0; lane < int'(BUS_BEW); lane++) begin
                if (data_be_i[lane]) begin
                    mem_q[wordIdx][lane*8 +: 8] <= data_wdata_i[lane*8 +: 8];
                end
            end
        end
    end

    // Build the response at handshake time: error for out-of-window, full word for reads, zero for writes.
    always_comb begin
        accResp = RESP_IDLE;
        if (!inRange) begin
            accResp.err = 1'b1;
        end else if (!data_we_i) begin
            accResp.rdata = mem_q[wordIdx];
        end
    end

    resp_delay_line #(
        .DEPTH (RESP_LAT)
    ) u_resp_delay_line (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .valid_i (handshake),
        .resp_i  (accResp),
        .valid_o (dlValid),
        .resp_o  (dlResp)
    );

    // Outputs are silenced during reset so a response already in the last slot is dropped, not shown.
    assign data_rvalid_o = dlValid & ~rst_i;
    assign data_rdata_o  = data_rvalid_o ? dlResp.rdata : '0;
    assign data_err_o    = data_rvalid_o & dlResp.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: three responder configurations driven by directed and random traffic,
// checked by a grant model and a response scoreboard fed from a behavioural memory model.
module tb_obi_mem_responder;

    localparam int          NDUT      = 3;
    localparam int          WORDS     = 1024;
    localparam logic [31:0] MEM_BYTES = 32'(4 * WORDS);
    localparam int          STALL [NDUT] = '{0, 3, 0};
    localparam int          LAT   [NDUT] = '{1, 2, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  we;
    logic [2:0]  rvalid;
    logic [2:0]  err;
    logic [3:0]  be    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] rdata [NDUT];

    exp_t        expQ      [NDUT][$];
    logic [31:0] model     [NDUT][WORDS];
    int          reqCycles [NDUT];
    longint      cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    obi_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .GNT_STALL(0), .RESP_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

    obi_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .GNT_STALL(3), .RESP_LAT(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

    obi_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .GNT_STALL(0), .RESP_LAT(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]), .data_we_i(we[2]),
        .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

    task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=%h expected=%h cycle=%0d", name, k, act, exp, cyc);
        end
    endtask

    // Reference memory: applies one accepted access and returns the response it must produce.
    function automatic exp_t modelAccess(input int k, input logic w, input logic [3:0] b,
                                         input logic [31:0] a, input logic [31:0] d, input longint due);
        exp_t e;
        int   idx;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.due   = due;
        if (a < MEM_BYTES) begin
            idx = int'(a >> 2);
            if (w) begin
                for (int lane = 0; lane < 4; lane++)
                    if (b[lane]) model[k][idx][lane*8 +: 8] = d[lane*8 +: 8];
            end else begin
                e.rdata = model[k][idx];
            end
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor: retires responses against the scoreboard, then predicts grants and queues new expectations.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   expGnt;
        for (int k = 0; k < NDUT; k++) begin
            if (rst[k]) begin
                expQ[k].delete();
                reqCycles[k] = 0;
            end
            if (rvalid[k]) begin
                if (expQ[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rvalid dut%0d actual=1 expected=0 cycle=%0d", k, cyc);
                end else begin
                    e = expQ[k].pop_front();
                    checkOutput("rdata", k, rdata[k], e.rdata);
                    checkOutput("err", k, 32'(err[k]), 32'(e.err));
                    checkOutput("resp_cycle", k, 32'(cyc), 32'(e.due));
                end
            end else begin
                checkOutput("idle_rdata", k, rdata[k], 32'h0);
                checkOutput("idle_err", k, 32'(err[k]), 32'h0);
                if (expQ[k].size() > 0 && expQ[k][0].due < cyc) begin
                    e = expQ[k].pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missing_rvalid dut%0d actual=0 expected=1 due=%0d cycle=%0d",
                             k, e.due, cyc);
                end
            end
            if (rst[k] || !req[k]) begin
                checkOutput("gnt_idle", k, 32'(gnt[k]), 32'h0);
            end else begin
                expGnt = (reqCycles[k] >= STALL[k]);
                checkOutput("gnt", k, 32'(gnt[k]), 32'(expGnt));
                if (expGnt) begin
                    expQ[k].push_back(modelAccess(k, we[k], be[k], addr[k], wdata[k], cyc + LAT[k]));
                    reqCycles[k] = 0;
                end else begin
                    reqCycles[k]++;
                end
            end
        end
    end

    // Presents one request and waits (bounded) for its grant; keep leaves req high for a back-to-back follower.
    task automatic applyStimulus(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                                 input logic [31:0] d, input bit keep,
                                 output longint startCyc, output longint hsCyc);
        int n    = 0;
        bit done = 0;
        req[k]   = 1'b1;
        we[k]    = w;
        be[k]    = b;
        addr[k]  = a;
        wdata[k] = d;
        startCyc = cyc;
        hsCyc    = -1;
        while (!done) begin
            @(negedge clk);
            if (gnt[k]) begin
                hsCyc = cyc;
                done  = 1;
            end else begin
                n++;
                if (n >= 64) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL grant_timeout dut%0d actual=no_gnt expected=gnt cycle=%0d", k, cyc);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!keep) req[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] randAddr();
        int r = $urandom_range(0, 9);
        if (r == 0) return $urandom();
        if (r == 1) return 32'h0000_1000 + 32'($urandom_range(0, 63));
        if (r < 6)  return 32'($urandom_range(0, 255));
        return 32'($urandom_range(0, 4095));
    endfunction

    task automatic randomTraffic(input int k, input int n);
        longint s, h;
        bit     keep;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                req[k]   = 1'b1;
                we[k]    = 1'($urandom_range(0, 1));
                be[k]    = 4'($urandom_range(0, 15));
                addr[k]  = randAddr();
                wdata[k] = $urandom();
                idle(1);
                req[k] = 1'b0;
            end else begin
                keep = (i != n - 1) && ($urandom_range(0, 1) == 1);
                applyStimulus(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), randAddr(),
                              $urandom(), keep, s, h);
                if (!keep) idle($urandom_range(0, 2));
            end
        end
        req[k] = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        longint s, h, prevH;
        logic [31:0] v;
        rst = 3'b111;
        req = 3'b000;
        we  = 3'b000;
        for (int k = 0; k < NDUT; k++) begin
            be[k] = 4'h0;
            addr[k] = 32'h0;
            wdata[k] = 32'h0;
            reqCycles[k] = 0;
        end
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom(); u_dut0.mem_q[i] = v; model[0][i] = v;
            v = $urandom(); u_dut1.mem_q[i] = v; model[1][i] = v;
            v = $urandom(); u_dut2.mem_q[i] = v; model[2][i] = v;
        end
        @(posedge clk);
        #1;
        // Requests during reset must never be granted.
        req = 3'b111;
        idle(3);
        req = 3'b000;
        rst = 3'b000;
        idle(2);

        // Full-word write then read back, grant in the request cycle.
        applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, s, h);
        checkOutput("gnt_same_cycle_wr", 0, 32'(h - s), 32'd0);
        applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, s, h);
        checkOutput("gnt_same_cycle_rd", 0, 32'(h - s), 32'd0);
        idle(2);

        // Partial-lane write merge.
        applyStimulus(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, s, h);
        applyStimulus(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0, s, h);
        applyStimulus(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 1'b0, s, h);
        applyStimulus(0, 1'b0, 4'h0, 32'h22, 32'h0, 1'b0, s, h);
        idle(2);

        // Read immediately following a write to the same word.
        applyStimulus(0, 1'b1, 4'hF, 32'h40, 32'h5, 1'b1, s, h);
        applyStimulus(0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, s, h);
        idle(2);

        // Out-of-window accesses, then read back every word to show nothing changed.
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, s, h);
        applyStimulus(0, 1'b1, 4'hF, 32'h0000_1000, 32'hCAFEF00D, 1'b0, s, h);
        applyStimulus(0, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h12345678, 1'b0, s, h);
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0, 1'b0, s, h);
        for (int i = 0; i < WORDS; i++)
            applyStimulus(0, 1'b0, 4'hF, 32'(i * 4), 32'h0, i != WORDS - 1, s, h);
        idle(3);

        // Stalled grants with the request held high across four transfers.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b0, 4'hF, 32'(32'h100 + 4 * i), 32'h0, i < 3, s, h);
            if (i == 0) checkOutput("first_gnt_delay", 1, 32'(h - s), 32'd3);
            else        checkOutput("gnt_spacing", 1, 32'(h - prevH), 32'd4);
            prevH = h;
        end
        idle(3);

        // A withdrawn request keeps the stall progress it made.
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h200;
        idle(2);
        req[1] = 1'b0;
        idle(3);
        applyStimulus(1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b0, s, h);
        checkOutput("gnt_after_withdraw", 1, 32'(h - s), 32'd1);
        idle(4);

        // Reset while three reads are in flight drops them all.
        applyStimulus(2, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, s, h);
        applyStimulus(2, 1'b0, 4'hF, 32'h14, 32'h0, 1'b1, s, h);
        applyStimulus(2, 1'b0, 4'hF, 32'h18, 32'h0, 1'b0, s, h);
        rst[2] = 1'b1;
        req[2] = 1'b1;
        idle(2);
        req[2] = 1'b0;
        rst[2] = 1'b0;
        idle(6);
        applyStimulus(2, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, s, h);
        idle(4);

        randomTraffic(0, 10000);
        randomTraffic(1, 400);
        randomTraffic(2, 600);

        idle(10);
        for (int k = 0; k < NDUT; k++)
            checkOutput("queue_drained", k, 32'(expQ[k].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
